component_reg_bank: RTL and testbench

//  Bus-facing register bank holding one component_registers_t (64 b) image.

---
 rtl/component_reg_bank_pkg.sv | 52 +++++
 rtl/component_reg_bank.sv | 125 ++++++++++++
 tb/tb_component_reg_bank.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/component_reg_bank_pkg.sv
// Register layout, bus masks and FSM encoding for component_reg_bank.
// The version field is constant hardware identification and is never writable.
package my_registers;

  typedef struct packed {
    logic [15:0] major;
    logic [15:0] minor;
  } version_register_t;

  // Word 0 is the version field, word 1 is the writable control word.
  typedef struct packed {
    logic [31:0]       control;
    version_register_t version;
  } component_registers_t;

  localparam int REGISTER_BITS = $bits(component_registers_t);

  typedef logic [REGISTER_BITS-1:0] register_bits_t;

  typedef enum logic [0:0] {
    BANK_IDLE = 1'b0,
    BANK_RESP = 1'b1
  } bank_state_e;

  localparam component_registers_t reg_read_mask = '{
    version: '{major: '1, minor: '1},
    default: '1
  };

  localparam component_registers_t reg_write_mask = '{
    version: '{major: '0, minor: '0},
    default: '1
  };

  localparam component_registers_t version_field_mask = '{
    version: '{major: '1, minor: '1},
    default: '0
  };

  localparam register_bits_t reg_read_mask_bits    = register_bits_t'(reg_read_mask);
  localparam register_bits_t reg_write_mask_bits   = register_bits_t'(reg_write_mask);
  localparam register_bits_t version_field_mask_bits = register_bits_t'(version_field_mask);

  // Flat image holding only the given version value in its field.
  function automatic register_bits_t place_version(input version_register_t v);
    component_registers_t img;
    img         = '0;
    img.version = v;
    return register_bits_t'(img);
  endfunction

endpackage

// File: rtl/component_reg_bank.sv
// Bus-facing register bank: serves one 64-bit register image as DATA_WIDTH words
// over a valid/ready request/response bus and drives the live image to the datapath.
module component_reg_bank
  import my_registers::*;
#(
  parameter int                DATA_WIDTH  = 32,
  parameter int                ADDR_WIDTH  = 4,
  parameter register_bits_t    READ_MASK   = reg_read_mask_bits,
  parameter register_bits_t    WRITE_MASK  = reg_write_mask_bits,
  parameter register_bits_t    RESET_VALUE = '0,
  parameter version_register_t VERSION     = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output component_registers_t  regs_out,
  output logic                  regs_wr_pulse
);

  localparam int NUM_WORDS = REGISTER_BITS / DATA_WIDTH;

  // Version bits are stripped from the write mask so no write can reach them.
  localparam register_bits_t WM_EFF      = WRITE_MASK & ~version_field_mask_bits;
  localparam register_bits_t IMAGE_RESET = (RESET_VALUE & ~version_field_mask_bits)
                                         | place_version(VERSION);

  bank_state_e             state_q, state_d;
  register_bits_t          image_q, image_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    wr_pulse_q, wr_pulse_d;

  logic                    in_range_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  register_bits_t          wr_image_s;

  // Word mux for reads and masked merge for writes at the addressed word.
  always_comb begin
    rd_word_s  = '0;
    wr_image_s = image_q;
    in_range_s = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(NUM_WORDS));
    for (int w = 0; w < NUM_WORDS; w++) begin
      rd_word_s |= (req_addr == ADDR_WIDTH'(w))
                 ? (image_q[w*DATA_WIDTH +: DATA_WIDTH] & READ_MASK[w*DATA_WIDTH +: DATA_WIDTH])
                 : '0;
      wr_image_s[w*DATA_WIDTH +: DATA_WIDTH] = (req_addr == ADDR_WIDTH'(w))
                 ? ((image_q[w*DATA_WIDTH +: DATA_WIDTH] & ~WM_EFF[w*DATA_WIDTH +: DATA_WIDTH])
                   | (req_wdata & WM_EFF[w*DATA_WIDTH +: DATA_WIDTH]))
                 : image_q[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic: accept in IDLE, hold the response until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    image_d     = image_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    wr_pulse_d  = 1'b0;
    case (state_q)
      BANK_IDLE: begin
        if (req_valid) begin
          state_d = BANK_RESP;
          if (!in_range_s) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
          end else if (req_write) begin
            image_d     = wr_image_s;
            wr_pulse_d  = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b0;
          end else begin
            rsp_rdata_d = rd_word_s;
            rsp_error_d = 1'b0;
          end
        end else begin
          state_d = BANK_IDLE;
        end
      end
      BANK_RESP: begin
        if (rsp_ready) begin
          state_d = BANK_IDLE;
        end else begin
          state_d = BANK_RESP;
        end
      end
      default: begin
        state_d = BANK_IDLE;
      end
    endcase
  end

  // State, image and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BANK_IDLE;
      image_q     <= IMAGE_RESET;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      wr_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      image_q     <= image_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  assign req_ready     = (state_q == BANK_IDLE);
  assign rsp_valid     = (state_q == BANK_RESP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_error     = rsp_error_q;
  assign regs_out      = component_registers_t'(image_q);
  assign regs_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_component_reg_bank.sv
// Randomised bench for component_reg_bank against a word-array model of the register image.
module tb_component_reg_bank;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [63:0] regs_out;
  logic        regs_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: word 0 is entirely the version field, word 1 is the control word.
  logic [31:0] mdl [2];
  logic [31:0] rm  [2];
  logic [31:0] wm  [2];

  component_reg_bank #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .READ_MASK  (64'hFFFF_0000_FFFF_FFFF),
    .WRITE_MASK (64'hFFFF_FFFF_FFFF_FFFF),
    .RESET_VALUE(64'h0),
    .VERSION    (32'h0001_2345)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .regs_out     (regs_out),
    .regs_wr_pulse(regs_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl[0] = 32'h0001_2345;
    mdl[1] = 32'h0;
  endtask

  // One bus transaction with optional response back-pressure and a junk request held during RESP.
  task automatic xact(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      input int stall, input bit junk, input string tag);
    logic        in_rng;
    logic [31:0] exp_rd;
    logic        exp_pulse;
    in_rng    = (addr < 4'd2);
    exp_rd    = 32'h0;
    exp_pulse = wr && in_rng;
    if (in_rng && !wr) exp_rd = mdl[addr[0]] & rm[addr[0]];
    if (wr && in_rng) mdl[addr[0]] = (mdl[addr[0]] & ~wm[addr[0]]) | (wd & wm[addr[0]]);

    @(negedge clk);
    check_eq({tag, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (stall == 0);

    @(negedge clk);
    if (junk) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'd1;
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    check_eq({tag, "_req_ready_resp"}, req_ready, 0);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
    check_eq({tag, "_error"}, rsp_error, !in_rng);
    check_eq({tag, "_wr_pulse"}, regs_wr_pulse, exp_pulse);
    check_eq({tag, "_regs_out"}, regs_out, {mdl[1], mdl[0]});

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, rsp_valid, 1);
      check_eq({tag, "_stall_rdata"}, rsp_rdata, exp_rd);
      check_eq({tag, "_stall_error"}, rsp_error, !in_rng);
      check_eq({tag, "_stall_ready"}, req_ready, 0);
      check_eq({tag, "_stall_pulse"}, regs_wr_pulse, 0);
    end
    rsp_ready = 1'b1;

    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "_post_valid"}, rsp_valid, 0);
    check_eq({tag, "_post_ready"}, req_ready, 1);
    check_eq({tag, "_post_pulse"}, regs_wr_pulse, 0);
    check_eq({tag, "_post_regs"}, regs_out, {mdl[1], mdl[0]});
    rsp_ready = 1'b0;
  endtask

  logic        r_wr;
  logic [3:0]  r_addr;
  logic [31:0] r_wd;
  int          r_stall;
  bit          r_junk;

  initial begin
    rm[0] = 32'hFFFF_FFFF;
    rm[1] = 32'hFFFF_0000;
    wm[0] = 32'h0000_0000;
    wm[1] = 32'hFFFF_FFFF;
    model_reset();

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 4'd0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_error", rsp_error, 0);
    check_eq("rst_pulse", regs_wr_pulse, 0);
    check_eq("rst_regs", regs_out, 64'h0000_0000_0001_2345);
    reset_n = 1'b1;

    xact(1'b0, 4'd0, 32'h0, 0, 1'b0, "t1_rd_version");
    xact(1'b1, 4'd1, 32'hDEAD_BEEF, 0, 1'b0, "t2_wr");
    check_eq("t2_regs_word1", regs_out, 64'hDEAD_BEEF_0001_2345);
    xact(1'b0, 4'd1, 32'h0, 0, 1'b0, "t3_rd_masked");
    xact(1'b1, 4'd0, 32'hFFFF_FFFF, 0, 1'b0, "t4_wr_version");
    check_eq("t4_regs_version", regs_out, 64'hDEAD_BEEF_0001_2345);
    xact(1'b0, 4'd0, 32'h0, 1, 1'b0, "t4_rd_version");
    xact(1'b0, 4'd5, 32'h0, 0, 1'b0, "t5_rd_oob");
    xact(1'b1, 4'd2, 32'h1234_5678, 2, 1'b1, "t5_wr_oob");
    xact(1'b0, 4'd15, 32'h0, 0, 1'b0, "t5_rd_top");
    xact(1'b0, 4'd1, 32'h0, 5, 1'b1, "t6_stall");

    for (int i = 0; i < 150; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      r_wd    = $urandom;
      r_stall = $urandom_range(0, 3);
      r_junk  = 1'($urandom_range(0, 1));
      xact(r_wr, r_addr, r_wd, r_stall, r_junk, "rand");
    end

    // Reset while a write response is pending: response dropped, write lost.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd1;
    req_wdata = 32'h1357_9BDF;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    mdl[1] = 32'h1357_9BDF;
    check_eq("t6_inflight_valid", rsp_valid, 1);
    check_eq("t6_inflight_regs", regs_out, {mdl[1], mdl[0]});
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6_rst_valid", rsp_valid, 0);
    check_eq("t6_rst_ready", req_ready, 1);
    check_eq("t6_rst_rdata", rsp_rdata, 0);
    check_eq("t6_rst_pulse", regs_wr_pulse, 0);
    check_eq("t6_rst_regs", regs_out, {mdl[1], mdl[0]});
    @(negedge clk);
    reset_n = 1'b1;
    xact(1'b0, 4'd1, 32'h0, 0, 1'b0, "t6_rd_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
